// File: rtl/segmented_display_decoder.sv
// Recovers the hex value shown on each digit of a multiplexed 7/8-segment display bus.
// The bus is sampled asynchronously; a digit is captured once its pattern has held steady.

module segmented_display_decoder #(
    parameter int number_of_segments = 7,
    parameter int number_of_nybbles  = 4,
    parameter int stable_cycles      = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [number_of_segments-1:0]  cathode,
    input  logic [number_of_nybbles-1:0]   anode,
    input  logic                           clear_error,
    output logic [number_of_nybbles*4-1:0] data,
    output logic [number_of_nybbles-1:0]   dp,
    output logic [number_of_nybbles-1:0]   valid,
    output logic                           frame_strobe,
    output logic                           error
);

    localparam int SAMPLE_W = number_of_nybbles + number_of_segments;
    localparam int DP_BIT   = (number_of_segments > 7) ? 7 : 0;
    localparam logic HAS_DP = (number_of_segments > 7) ? 1'b1 : 1'b0;
    // Idle bus: all cathodes dark (high) and no digit selected.
    localparam logic [SAMPLE_W-1:0] SAMPLE_RESET =
        {{number_of_nybbles{1'b0}}, {number_of_segments{1'b1}}};
    localparam logic [7:0] CAPTURE_COUNT = 8'(stable_cycles - 1);
    localparam logic [7:0] COUNT_MAX     = 8'hFF;

    // Active-low g..a pattern to {match, nybble}.
    function automatic logic [4:0] decode_segments(input logic [6:0] seg);
        logic [4:0] result;
        case (seg)
            7'b1000000: result = {1'b1, 4'h0};
            7'b1111001: result = {1'b1, 4'h1};
            7'b0100100: result = {1'b1, 4'h2};
            7'b0110000: result = {1'b1, 4'h3};
            7'b0011001: result = {1'b1, 4'h4};
            7'b0010010: result = {1'b1, 4'h5};
            7'b0000010: result = {1'b1, 4'h6};
            7'b1111000: result = {1'b1, 4'h7};
            7'b0000000: result = {1'b1, 4'h8};
            7'b0010000: result = {1'b1, 4'h9};
            7'b0001000: result = {1'b1, 4'hA};
            7'b0000011: result = {1'b1, 4'hB};
            7'b0100111: result = {1'b1, 4'hC};
            7'b0100001: result = {1'b1, 4'hD};
            7'b0000110: result = {1'b1, 4'hE};
            7'b0001110: result = {1'b1, 4'hF};
            default:    result = {1'b0, 4'h0};
        endcase
        return result;
    endfunction

    function automatic logic is_one_hot(input logic [number_of_nybbles-1:0] v);
        int unsigned ones;
        ones = 32'd0;
        for (int i = 0; i < number_of_nybbles; i++) begin
            ones = ones + {31'd0, v[i]};
        end
        return (ones == 32'd1);
    endfunction

    logic [SAMPLE_W-1:0]            sync1_r;
    logic [SAMPLE_W-1:0]            sync2_r;
    logic [SAMPLE_W-1:0]            prev_r;
    logic [7:0]                     count_r;
    logic [number_of_nybbles*4-1:0] data_r;
    logic [number_of_nybbles-1:0]   dp_r;
    logic [number_of_nybbles-1:0]   valid_r;
    logic                           frame_strobe_r;
    logic                           error_r;

    logic [number_of_nybbles-1:0]   anode_prev_s;
    logic [number_of_segments-1:0]  cathode_prev_s;
    logic [4:0]                     decoded_s;
    logic [3:0]                     nybble_s;
    logic                           match_s;
    logic                           changed_s;
    logic                           capture_s;
    logic                           dp_bit_s;

    // Two-flop synchronizer followed by the previous-sample register used for change detection.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_r <= SAMPLE_RESET;
            sync2_r <= SAMPLE_RESET;
            prev_r  <= SAMPLE_RESET;
        end else begin
            sync1_r <= {anode, cathode};
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Capture decision and decode of the pattern that has been holding steady.
    always_comb begin
        anode_prev_s   = prev_r[SAMPLE_W-1 -: number_of_nybbles];
        cathode_prev_s = prev_r[number_of_segments-1:0];
        changed_s      = (sync2_r != prev_r);
        // The counter passes CAPTURE_COUNT only once per run and saturates above it.
        capture_s      = (count_r == CAPTURE_COUNT) && is_one_hot(anode_prev_s);
        decoded_s      = decode_segments(cathode_prev_s[6:0]);
        match_s        = decoded_s[4];
        nybble_s       = decoded_s[3:0];
        if (HAS_DP) begin
            dp_bit_s = ~cathode_prev_s[DP_BIT];
        end else begin
            dp_bit_s = 1'b0;
        end
    end

    // Stability counter: restarts on any change, saturates at its maximum.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_r <= 8'd0;
        end else if (changed_s) begin
            count_r <= 8'd0;
        end else if (count_r != COUNT_MAX) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Per-digit result registers, frame strobe and sticky error.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_r         <= '0;
            dp_r           <= '0;
            valid_r        <= '0;
            frame_strobe_r <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            frame_strobe_r <= capture_s && anode_prev_s[number_of_nybbles-1];
            if (capture_s && !match_s) begin
                error_r <= 1'b1;
            end else if (clear_error) begin
                error_r <= 1'b0;
            end else begin
                error_r <= error_r;
            end
            for (int k = 0; k < number_of_nybbles; k++) begin
                if (capture_s && anode_prev_s[k]) begin
                    if (match_s) begin
                        data_r[4*k +: 4] <= nybble_s;
                        dp_r[k]          <= dp_bit_s;
                        valid_r[k]       <= 1'b1;
                    end else begin
                        valid_r[k]       <= 1'b0;
                    end
                end
            end
        end
    end

    assign data         = data_r;
    assign dp           = dp_r;
    assign valid        = valid_r;
    assign frame_strobe = frame_strobe_r;
    assign error        = error_r;

endmodule

// File: tb/tb_segmented_display_decoder.sv
// Bench for segmented_display_decoder: 7- and 8-segment builds driven from one bus,
// each compared every clock against a run-length reference model.

module tb_segmented_display_decoder;

    localparam int SC = 8;
    localparam logic [11:0] RST_PAT = 12'h0FF;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        clear_error;
    logic [7:0]  cath;
    logic [3:0]  anode;

    logic [15:0] data0, data1;
    logic [3:0]  dp0, dp1, valid0, valid1;
    logic        strobe0, strobe1, error0, error1;

    always #5 clock = ~clock;

    segmented_display_decoder dut7 (
        .clock(clock), .reset_n(reset_n), .cathode(cath[6:0]), .anode(anode),
        .clear_error(clear_error), .data(data0), .dp(dp0), .valid(valid0),
        .frame_strobe(strobe0), .error(error0)
    );

    segmented_display_decoder #(.number_of_segments(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .cathode(cath), .anode(anode),
        .clear_error(clear_error), .data(data1), .dp(dp1), .valid(valid1),
        .frame_strobe(strobe1), .error(error1)
    );

    logic [6:0] seg_table [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic        inst;
        int          due;
        logic [11:0] sample;
    } cap_t;

    cap_t        pend[$];
    logic [11:0] m_last  [2];
    int          m_run   [2];
    logic [15:0] m_data  [2];
    logic [3:0]  m_dp    [2];
    logic [3:0]  m_valid [2];
    logic        m_strobe[2];
    logic        m_error [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_count = 0;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, actual, expected);
        end
    endtask

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (seg_table[i] == p) return i;
        end
        return -1;
    endfunction

    // Reference model evaluated once per rising edge with the pin values sampled at that edge.
    task automatic model_edge();
        logic [11:0] sample;
        logic        set_err [2];
        cap_t        c;
        int          k, v;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            m_strobe[i] = 1'b0;
            set_err[i]  = 1'b0;
        end
        if (!reset_n) begin
            pend.delete();
            for (int i = 0; i < 2; i++) begin
                m_last[i]  = RST_PAT;
                m_run[i]   = 3;
                m_data[i]  = 16'h0;
                m_dp[i]    = 4'h0;
                m_valid[i] = 4'h0;
                m_error[i] = 1'b0;
            end
        end else begin
            while (pend.size() > 0 && pend[0].due == cyc) begin
                c = pend.pop_front();
                k = 0;
                for (int b = 0; b < 4; b++) if (c.sample[8+b]) k = b;
                v = lookup(c.sample[6:0]);
                if (v >= 0) begin
                    m_data[c.inst][4*k +: 4] = 4'(v);
                    m_valid[c.inst][k]       = 1'b1;
                    m_dp[c.inst][k]          = c.inst ? ~c.sample[7] : 1'b0;
                end else begin
                    m_valid[c.inst][k] = 1'b0;
                    set_err[c.inst]    = 1'b1;
                end
                if (k == 3) m_strobe[c.inst] = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                if (set_err[i]) m_error[i] = 1'b1;
                else if (clear_error) m_error[i] = 1'b0;
                sample = {anode, (i == 1) ? cath : {1'b1, cath[6:0]}};
                if (sample == m_last[i]) begin
                    if (m_run[i] < 100000) m_run[i]++;
                end else begin
                    m_run[i]  = 1;
                    m_last[i] = sample;
                end
                if (m_run[i] == SC && $countones(sample[11:8]) == 1)
                    pend.push_back('{inst: 1'(i), due: cyc + 3, sample: sample});
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        if (strobe0) strobe_count++;
        check_value("data7",   {16'h0, data0},  {16'h0, m_data[0]});
        check_value("dp7",     {28'h0, dp0},    {28'h0, m_dp[0]});
        check_value("valid7",  {28'h0, valid0}, {28'h0, m_valid[0]});
        check_value("strobe7", {31'h0, strobe0}, {31'h0, m_strobe[0]});
        check_value("error7",  {31'h0, error0},  {31'h0, m_error[0]});
        check_value("data8",   {16'h0, data1},  {16'h0, m_data[1]});
        check_value("dp8",     {28'h0, dp1},    {28'h0, m_dp[1]});
        check_value("valid8",  {28'h0, valid1}, {28'h0, m_valid[1]});
        check_value("strobe8", {31'h0, strobe1}, {31'h0, m_strobe[1]});
        check_value("error8",  {31'h0, error1},  {31'h0, m_error[1]});
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] c, input int n);
        anode = a;
        cath  = c;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_clear();
        clear_error = 1'b1;
        step();
        clear_error = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_error = 1'b0;
        anode = 4'h0;
        cath  = 8'hFF;
        for (int i = 0; i < 3; i++) step();
        check_value("reset_data", {16'h0, data0}, 32'h0);
        reset_n = 1'b1;
        hold(4'h0, 8'hFF, 4);

        // Single digit '2' on digit 0: appears on the 11th clock after the pins change.
        anode = 4'b0001;
        cath  = 8'b10100100;
        for (int t = 1; t <= 20; t++) begin
            step();
            if (t == 10) check_value("lat_early_valid", {28'h0, valid0}, 32'h0);
            if (t == 11) begin
                check_value("lat_data", {28'h0, data0[3:0]}, 32'h2);
                check_value("lat_valid", {28'h0, valid0}, 32'h1);
            end
        end

        // Scan D,E,A,D on digits 3..0.
        strobe_count = 0;
        hold(4'b1000, {1'b1, seg_table[13]}, 16);
        hold(4'b0100, {1'b1, seg_table[14]}, 16);
        hold(4'b0010, {1'b1, seg_table[10]}, 16);
        hold(4'b0001, {1'b1, seg_table[13]}, 16);
        check_value("dead_data", {16'h0, data0}, 32'h0000DEAD);
        check_value("dead_valid", {28'h0, valid0}, 32'hF);
        check_value("dead_strobes", 32'(strobe_count), 32'd1);

        // Unknown pattern on digit 2, then clear.
        hold(4'b0100, 8'b11010101, 14);
        check_value("bad_error", {31'h0, error0}, 32'h1);
        check_value("bad_valid2", {31'h0, valid0[2]}, 32'h0);
        check_value("bad_data2", {28'h0, data0[11:8]}, 32'hE);
        pulse_clear();
        check_value("clr_error", {31'h0, error0}, 32'h0);

        // Fast toggling and multi-hot anode must not capture.
        for (int i = 0; i < 6; i++) hold(4'b0001, (i % 2) ? {1'b1, seg_table[7]} : {1'b1, seg_table[8]}, 5);
        hold(4'b0011, {1'b1, seg_table[3]}, 20);
        check_value("nocap_data", {16'h0, data0}, 32'h0000DEAD);

        // Decimal point on digit 3 for the 8-segment build.
        hold(4'b1000, 8'b01111001, 14);
        check_value("dp8_digit3", {31'h0, dp1[3]}, 32'h1);
        check_value("dp8_data3", {28'h0, data1[15:12]}, 32'h1);
        check_value("dp7_zero", {28'h0, dp0}, 32'h0);

        // Reset in the middle of a run, then a fresh run after release.
        hold(4'h0, 8'hFF, 3);
        hold(4'b0010, {1'b1, seg_table[5]}, 8);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_value("midreset_valid", {28'h0, valid0}, 32'h0);
        for (int t = 1; t <= 12; t++) begin
            step();
            if (t == 10) check_value("post_rst_early", {28'h0, valid0}, 32'h0);
            if (t == 11) check_value("post_rst_valid", {28'h0, valid0}, 32'h2);
        end

        // Very long hold: still a single capture.
        strobe_count = 0;
        hold(4'b1000, {1'b0, seg_table[9]}, 300);
        check_value("long_strobes", 32'(strobe_count), 32'd1);

        // Randomized bursts.
        for (int s = 0; s < 180; s++) begin
            int r;
            logic [3:0] a;
            logic [7:0] c;
            r = int'($urandom_range(0, 99));
            if (r < 70) a = 4'(1 << $urandom_range(0, 3));
            else if (r < 85) a = 4'h0;
            else a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 75) c = {1'($urandom_range(0, 1)), seg_table[$urandom_range(0, 15)]};
            else c = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) < 2) reset_n = 1'b0;
            anode = a;
            cath  = c;
            for (int t = 0; t < int'($urandom_range(1, 24)); t++) begin
                clear_error = ($urandom_range(0, 99) < 5);
                step();
                reset_n = 1'b1;
            end
            clear_error = 1'b0;
        end
        hold(4'h0, 8'hFF, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/segmented_display_decoder.md
SEGMENTED_DISPLAY_DECODER -- requirements
Module: segmented_display_decoder

Interface
REQ-001 The block SHALL have parameter number_of_segments, default 7, meaning the segment line count: 7 gives a-g; 8 gives a-g plus dp.
REQ-002 The block SHALL have parameter number_of_nybbles, default 4, meaning the digit count and anode width.
REQ-003 The block SHALL have parameter stable_cycles, default 8, meaning the consecutive clocks a pattern must hold before capture (legal range 2..255).
REQ-004 clock  input  1  sole clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset; synchronous, active-low.
REQ-006 cathode  input  number_of_segments  segment lines, active-low; bit0=a, bit1=b ... bit6=g, bit7=dp when present; asynchronous to clock.
REQ-007 anode  input  number_of_nybbles  digit enables, active-high, one-hot when a digit is lit; asynchronous to clock.
REQ-008 clear_error  input  1  single-cycle request to clear error.
REQ-009 data  output  number_of_nybbles*4  decoded hex value; digit k occupies bits 4k+3:4k.
REQ-010 dp  output  number_of_nybbles  decimal point per digit, active-high; stays 0 when number_of_segments is 7.
REQ-011 valid  output  number_of_nybbles  per-digit flag; 1 = last capture for that digit decoded cleanly.
REQ-012 frame_strobe  output  1  one-cycle pulse on each capture of digit number_of_nybbles-1.
REQ-013 error  output  1  sticky flag for an unrecognized segment pattern.

Function
REQ-014 Inputs: cathode and anode SHALL each pass through a 2-flop synchronizer before any other use.
REQ-015 Stability counter: compare synchronized {anode,cathode} each clock with its previous-cycle value.
- Change: counter restarts at 0.
- No change: counter increments, saturating at 255.
REQ-016 Capture condition: the cycle the counter reaches stable_cycles-1, with the synchronized anode exactly one-hot.
- Exactly one capture per stable run.
- Capture index k = position of the set anode bit.
REQ-017 Anode all-zero or multi-hot: no capture; counter still runs; data, dp and valid are unchanged.
REQ-018 Decode table, cathode[6:0] -> nybble (as binary g..a):
- 0:1000000  1:1111001  2:0100100  3:0110000  4:0011001  5:0010010  6:0000010  7:1111000
- 8:0000000  9:0010000  a:0001000  b:0000011  c:0100111  d:0100001  e:0000110  f:0001110
REQ-019 Matching capture, on the following clock:
- data digit k <= table value.
- valid[k] <= 1.
- dp[k] <= ~cathode[7] when 8 segments.
REQ-020 Non-matching capture, on the following clock:
- data digit k and dp[k] hold.
- valid[k] <= 0.
- error <= 1.
REQ-021 frame_strobe SHALL assert for exactly one clock, on the same clock as the data update for digit number_of_nybbles-1, whether that capture matched or not.
REQ-022 Latency: data, dp, valid and frame_strobe SHALL update stable_cycles+3 clocks after a stable input pattern first appears at the pins (2 synchronizer + stable_cycles + 1 register).
REQ-023 error stays set until clear_error is sampled high.
- If clear_error coincides with a new non-matching capture, error SHALL remain 1 (set wins).
REQ-024 An input change on the same cycle the counter would reach stable_cycles-1 SHALL suppress the capture (counter restarts).
REQ-025 Inputs stable for longer than 255 clocks SHALL produce no further captures until the pattern changes.

Reset
REQ-026 While reset_n is low at a clock edge, the following SHALL reset:
- Outputs: data=0, dp=0, valid=0, frame_strobe=0, error=0.
- Internals: synchronizers and previous-value register to all-ones cathode / zero anode; stability counter to 0.
REQ-027 Reset asserted mid-run SHALL discard any pending capture; the first capture after release needs a full stable_cycles run of new samples.

Verification
REQ-028 anode=0001, cathode=7'b0100100 held 20 clocks -> data[3:0]=2, valid=0001 at clock 11 after the pins change, one capture only.
REQ-029 Scan digits 3..0 with values 4'hD,4'hE,4'hA,4'hD, each held 16 clocks -> data=16'hDEAD, valid=1111, one frame_strobe, at digit-3 capture.
REQ-030 anode=0100, cathode=7'b1010101 -> valid[2]=0, error=1, data digit 2 unchanged; clear_error pulse -> error=0.
REQ-031 cathode toggles every 5 clocks with stable_cycles=8 -> no capture, data/valid unchanged; anode=0011 held 20 clocks -> no capture.
REQ-032 8-segment build, anode=1000, cathode=8'b01111001 -> data[15:12]=1, dp[3]=1.
REQ-033 reset_n low for 1 clock at counter=6 of a run -> all outputs 0; next capture only after 8 fresh stable clocks.
